// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC register, single-outstanding instruction-memory
// request FSM (REQ/WAIT/DROP) and the IF/ID pipeline register.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_pc_in,
  input  logic        i_br_taken,
  output logic [31:0] o_pc_out,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_id_ready,
  output logic        o_id_valid,
  output logic [31:0] o_id_pc,
  output logic [31:0] o_id_instr
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic        r_id_valid;
  logic        w_id_valid_nxt;
  logic [31:0] r_id_pc;
  logic [31:0] w_id_pc_nxt;
  logic [31:0] r_id_instr;
  logic [31:0] w_id_instr_nxt;
  logic        w_imem_req;

  // Next-state, PC and IF/ID update; a redirect overrides everything else.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_id_valid_nxt = r_id_valid;
    w_id_pc_nxt    = r_id_pc;
    w_id_instr_nxt = r_id_instr;
    w_imem_req     = 1'b0;

    if (r_id_valid && i_id_ready) begin
      w_id_valid_nxt = 1'b0;
      w_id_instr_nxt = NOP_INSTR;
    end

    case (r_state)
      ST_REQ: begin
        w_imem_req = (~r_id_valid | i_id_ready) & ~i_br_taken & ~i_rst;
        if (w_imem_req && i_imem_gnt) begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_br_taken) begin
          w_state_nxt = i_imem_rvalid ? ST_REQ : ST_DROP;
        end else if (i_imem_rvalid) begin
          w_id_valid_nxt = 1'b1;
          w_id_pc_nxt    = r_pc;
          w_id_instr_nxt = i_imem_rdata;
          w_pc_nxt       = i_pc_in;
          w_state_nxt    = ST_REQ;
        end
      end
      ST_DROP: begin
        if (i_imem_rvalid) begin
          w_state_nxt = ST_REQ;
        end
      end
      default: begin
        w_state_nxt = ST_REQ;
      end
    endcase

    if (i_br_taken) begin
      w_pc_nxt       = i_pc_in;
      w_id_valid_nxt = 1'b0;
      w_id_instr_nxt = NOP_INSTR;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_REQ;
      r_pc       <= RESET_PC;
      r_id_valid <= 1'b0;
      r_id_pc    <= 32'd0;
      r_id_instr <= NOP_INSTR;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_id_valid <= w_id_valid_nxt;
      r_id_pc    <= w_id_pc_nxt;
      r_id_instr <= w_id_instr_nxt;
    end
  end

  assign o_pc_out    = r_pc;
  assign o_imem_addr = r_pc;
  assign o_imem_req  = w_imem_req;
  assign o_id_valid  = r_id_valid;
  assign o_id_pc     = r_id_pc;
  assign o_id_instr  = r_id_instr;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: abstract fetch model checked every cycle
// plus hand-computed literal expectations for each scenario.
module tb_if_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, br, gnt, rvalid, rdy;
  logic [31:0] pc_in, rdata;
  logic [31:0] pc_out, addr, idpc, idinstr;
  logic        req, idv;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .i_clk(clk), .i_rst(rst), .i_pc_in(pc_in), .i_br_taken(br),
    .o_pc_out(pc_out), .o_imem_req(req), .o_imem_addr(addr),
    .i_imem_gnt(gnt), .i_imem_rvalid(rvalid), .i_imem_rdata(rdata),
    .i_id_ready(rdy), .o_id_valid(idv), .o_id_pc(idpc), .o_id_instr(idinstr)
  );

  // Model: a fetch is either idle, in flight, or in flight but already flushed.
  logic [31:0] m_pc, m_idpc, m_idinstr;
  logic        m_idv, m_busy, m_stale;
  logic        m_live = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    logic [31:0] n_pc, n_idpc, n_ins;
    logic        n_idv, n_busy, n_stale, fire, resp;
    n_pc = m_pc; n_idpc = m_idpc; n_ins = m_idinstr;
    n_idv = m_idv; n_busy = m_busy; n_stale = m_stale;
    if (rst) begin
      n_pc = RST_PC; n_idv = 1'b0; n_idpc = 32'd0; n_ins = NOP;
      n_busy = 1'b0; n_stale = 1'b0;
    end else begin
      fire = !m_busy && (!m_idv || rdy) && !br && gnt;
      resp = m_busy && rvalid;
      if (m_idv && rdy) begin
        n_idv = 1'b0; n_ins = NOP;
      end
      if (fire) n_busy = 1'b1;
      if (resp) begin
        n_busy = 1'b0; n_stale = 1'b0;
        if (!m_stale && !br) begin
          n_idv = 1'b1; n_idpc = m_pc; n_ins = rdata; n_pc = pc_in;
        end
      end
      if (br) begin
        n_pc = pc_in; n_idv = 1'b0; n_ins = NOP;
        if (m_busy && !rvalid) n_stale = 1'b1;
      end
    end
    m_pc <= n_pc; m_idpc <= n_idpc; m_idinstr <= n_ins;
    m_idv <= n_idv; m_busy <= n_busy; m_stale <= n_stale;
    m_live <= 1'b1;
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_live) begin
      check("m_req", 32'(req), 32'(!m_busy && (!m_idv || rdy) && !br && !rst));
      check("m_pc_out", pc_out, m_pc);
      check("m_addr", addr, m_pc);
      check("m_id_valid", 32'(idv), 32'(m_idv));
      check("m_id_pc", idpc, m_idpc);
      check("m_id_instr", idinstr, m_idinstr);
    end
  end

  // One cycle: drive inputs after the edge, return just after the next falling edge.
  task automatic cyc(input logic rst_i, input logic br_i, input logic [31:0] tgt,
                     input logic gnt_i, input logic rv_i, input logic [31:0] rd_i,
                     input logic rdy_i);
    @(posedge clk);
    #2;
    rst = rst_i; br = br_i; gnt = gnt_i; rvalid = rv_i; rdata = rd_i; rdy = rdy_i;
    pc_in = br_i ? tgt : m_pc + 32'd4;
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; br = 1'b0; gnt = 1'b0; rvalid = 1'b0; rdy = 1'b0;
    pc_in = 32'd0; rdata = 32'd0;

    // Reset state; request held low even with grant and ready asserted.
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 0, 0, 1);
    check("rst_pc", pc_out, 32'h0);
    check("rst_idv", 32'(idv), 32'd0);
    check("rst_idpc", idpc, 32'h0);
    check("rst_instr", idinstr, 32'h13);
    check("rst_req", 32'(req), 32'd0);

    // First fetch after reset release.
    cyc(0, 0, 0, 1, 0, 0, 1);
    check("f1_req", 32'(req), 32'd1);
    check("f1_addr", addr, 32'h0);
    cyc(0, 0, 0, 0, 1, 32'h00500093, 1);
    check("f1_wait_req", 32'(req), 32'd0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    check("f1_idv", 32'(idv), 32'd1);
    check("f1_idpc", idpc, 32'h0);
    check("f1_instr", idinstr, 32'h00500093);
    check("f1_addr_next", addr, 32'h4);
    check("stall_req0", 32'(req), 32'd0);

    // Decode stall: IF/ID holds, no request.
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 0, 1, 0, 0, 0);
      check("stall_req", 32'(req), 32'd0);
      check("stall_instr", idinstr, 32'h00500093);
      check("stall_addr", addr, 32'h4);
    end
    cyc(0, 0, 0, 1, 0, 0, 1);
    check("unstall_req", 32'(req), 32'd1);
    check("unstall_addr", addr, 32'h4);
    cyc(0, 0, 0, 0, 1, 32'h00a00113, 1);

    // Redirect while waiting; late response discarded.
    cyc(0, 0, 0, 1, 0, 0, 1);
    check("f2_idpc", idpc, 32'h4);
    check("f2_instr", idinstr, 32'h00a00113);
    check("f3_addr", addr, 32'h8);
    cyc(0, 1, 32'h100, 0, 0, 0, 1);
    check("br_wait_req", 32'(req), 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    check("drop_req", 32'(req), 32'd0);
    check("drop_pc", pc_out, 32'h100);
    check("drop_idv", 32'(idv), 32'd0);
    check("drop_instr", idinstr, 32'h13);
    cyc(0, 0, 0, 1, 1, 32'hdeadbeef, 1);
    check("drop_rv_req", 32'(req), 32'd0);
    cyc(0, 0, 0, 1, 0, 0, 1);
    check("post_drop_req", 32'(req), 32'd1);
    check("post_drop_addr", addr, 32'h100);
    check("post_drop_idv", 32'(idv), 32'd0);

    // Redirect and response on the same edge: straight back to REQ.
    cyc(0, 1, 32'h200, 0, 1, 32'hbad0bad0, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 1);
      check("gnt_low_req", 32'(req), 32'd1);
      check("gnt_low_addr", addr, 32'h200);
      check("gnt_low_idv", 32'(idv), 32'd0);
    end
    cyc(0, 0, 0, 1, 0, 0, 1);

    // Reset while waiting; stale response after release is ignored.
    cyc(1, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1, 32'h11111111, 1);
    check("rst_wait_req", 32'(req), 32'd1);
    check("rst_wait_addr", addr, 32'h0);
    cyc(0, 0, 0, 1, 0, 0, 1);
    check("rst_stale_idv", 32'(idv), 32'd0);
    cyc(0, 0, 0, 0, 1, 32'h00100073, 1);
    check("rst_wait_idv", 32'(idv), 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    check("rst_f_idv", 32'(idv), 32'd1);
    check("rst_f_idpc", idpc, 32'h0);
    check("rst_f_instr", idinstr, 32'h00100073);

    // Redirect in REQ with a held entry, then two redirects while in DROP.
    cyc(0, 0, 0, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 1, 32'h00200193, 0);
    cyc(0, 1, 32'h300, 1, 0, 0, 0);
    check("br_req_req", 32'(req), 32'd0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    check("br_req_idv", 32'(idv), 32'd0);
    check("br_req_pc", pc_out, 32'h300);
    cyc(0, 1, 32'h400, 0, 0, 0, 0);
    cyc(0, 1, 32'h500, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    check("br_drop_req", 32'(req), 32'd0);
    check("br_drop_pc", pc_out, 32'h500);
    cyc(0, 0, 0, 1, 1, 32'h0badf00d, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    check("drop_exit_addr", addr, 32'h500);
    cyc(0, 0, 0, 0, 1, 32'hcafe0001, 1);

    // Back-to-back fetches at one instruction per two cycles.
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 0, 1, 0, 0, 1);
      check("tp_idv", 32'(idv), 32'd1);
      check("tp_addr", addr, 32'h504 + 32'(4 * k));
      check("tp_idpc", idpc, 32'h500 + 32'(4 * k));
      cyc(0, 0, 0, 0, 1, 32'h0010_0000 + 32'(k), 1);
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("tp_last_instr", idinstr, 32'h0010_0003);
    check("tp_last_pc", pc_out, 32'h514);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013, SHALL be the instruction word held in the IF/ID register when it is empty or reset.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 pc_in  input  32  SHALL be the next-PC value from the next-PC selection logic (PC+4 or branch target).
REQ-006 br_taken  input  1  SHALL indicate a redirect from execute; when high, pc_in holds the target.
REQ-007 pc_out  output  32  SHALL be the current PC register value, fed to next-PC selection.
REQ-008 imem_req  output  1  SHALL be the instruction-memory request valid.
REQ-009 imem_addr  output  32  SHALL be the request address, always equal to pc_out.
REQ-010 imem_gnt  input  1  SHALL be the memory accept; a request transfers when imem_req and imem_gnt are high on the same edge.
REQ-011 imem_rvalid  input  1  SHALL mark imem_rdata valid, no earlier than the cycle after grant.
REQ-012 imem_rdata  input  32  SHALL be the returned instruction word.
REQ-013 id_ready  input  1  SHALL indicate decode consumes the IF/ID entry this cycle.
REQ-014 id_valid, id_pc, id_instr  output  1/32/32  SHALL be the IF/ID register: valid flag, fetch PC, instruction.

Function
REQ-015 FSM states SHALL be REQ (may issue), WAIT (one request outstanding), DROP (outstanding response to discard); at most one request outstanding.
REQ-016 In REQ, imem_req SHALL equal (~id_valid | id_ready) & ~br_taken & ~rst, combinationally.
REQ-017 REQ -> WAIT on imem_req & imem_gnt; otherwise remain in REQ.
REQ-018 WAIT, imem_rvalid & ~br_taken: id_valid<=1, id_pc<=pc_out, id_instr<=imem_rdata, PC<=pc_in, -> REQ.
REQ-019 WAIT, br_taken & ~imem_rvalid: PC<=pc_in, id_valid<=0, id_instr<=NOP_INSTR, -> DROP.
REQ-020 WAIT, br_taken & imem_rvalid: imem_rdata discarded, PC<=pc_in, id_valid<=0, -> REQ.
REQ-021 DROP: imem_req=0; on imem_rvalid discard data, -> REQ; br_taken in DROP SHALL load PC<=pc_in and stay DROP (or -> REQ if imem_rvalid same cycle).
REQ-022 br_taken in REQ SHALL load PC<=pc_in, clear id_valid, issue no request that cycle.
REQ-023 PC SHALL change only per REQ-018..REQ-022; no other PC writes.
REQ-024 IF/ID SHALL hold all fields while id_valid & ~id_ready & ~br_taken; on id_ready with no capture, id_valid<=0.
REQ-025 br_taken SHALL have priority over id_ready and capture in every state.
REQ-026 imem_rvalid in REQ SHALL be ignored (spurious/stale response).
REQ-027 Peak throughput SHALL be one instruction per two cycles (grant cycle, response cycle).

Reset
REQ-028 While rst high: PC=RESET_PC, state=REQ, id_valid=0, id_pc=0, id_instr=NOP_INSTR, imem_req=0.
REQ-029 Reset mid-WAIT/DROP SHALL abandon the outstanding request; a later imem_rvalid SHALL be ignored per REQ-026.
REQ-030 First request SHALL issue the cycle after rst deasserts, address RESET_PC.

Verification
REQ-031 Reset release, gnt=1, rvalid one cycle later with 32'h00500093, id_ready=1 -> id_valid=1, id_pc=0, id_instr=32'h00500093; next request address 0x4.
REQ-032 id_ready=0 with id_valid=1 for 3 cycles -> imem_req=0, IF/ID unchanged; id_ready=1 -> request to next PC in same cycle.
REQ-033 br_taken=1, pc_in=0x100 while in WAIT, rvalid two cycles later -> response discarded, id_valid=0, next imem_addr=0x100.
REQ-034 br_taken and imem_rvalid same cycle in WAIT -> data dropped, state REQ, pc_out=pc_in, no DROP cycle.
REQ-035 rst asserted in WAIT, rvalid arrives after release -> ignored; first request address RESET_PC, id_valid stays 0 until its response.
REQ-036 imem_gnt held low 5 cycles in REQ -> imem_req stays 1, imem_addr stable, PC unchanged.
